min_max_stream_reducer: RTL and testbench
=========================================

Name: min_max_stream_reducer

Overview:
- Streaming reduction block. It accepts a frame of unsigned samples over a valid/ready/last input stream.
- It tracks the running minimum, running maximum and sample count for the frame.
- It presents the registered min/max/count result on a valid/ready output handshake.
- It is the consumer-side counterpart of the pairwise Min_Max compare stage. It sits downstream of sample producers and feeds statistics/monitor logic.

Parameters:
- DATA_W, 8, sample width; unsigned compare.
- CNT_W, 8, frame sample counter width; the counter saturates.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  DATA_W  sample value.
- in_valid  input  1  in_data is valid this cycle.
- in_last  input  1  the current beat is the final sample of the frame. Qualified by in_valid.
- in_ready  output  1  block can accept a beat this cycle.
- out_min  output  DATA_W  minimum of the completed frame.
- out_max  output  DATA_W  maximum of the completed frame.
- out_count  output  CNT_W  number of samples in the frame, saturating.
- out_valid  output  1  result is valid.
- out_ready  input  1  downstream accepts the result.

Behaviour:
- Reset (rst=1, asynchronous):
  - state=IDLE
  - out_min=0, out_max=0, out_count=0, out_valid=0
  - internal run_min/run_max/run_cnt=0
  - in_ready=1 once rst deasserts
- Reset mid-frame or mid-HOLD discards all partial or pending results. No output is produced for that frame.
- Beat accepted when in_valid & in_ready at a rising edge.
- States:
  - IDLE: no sample of the current frame has been taken. in_ready=1, out_valid=0.
    - On accept: run_min=run_max=in_data, run_cnt=1.
    - If in_last=1, latch the result and go to HOLD. Otherwise go to ACCUM.
  - ACCUM: in_ready=1, out_valid=0.
    - On accept: run_min=min(run_min,in_data), run_max=max(run_max,in_data), run_cnt=run_cnt+1, saturating at 2^CNT_W-1.
    - If in_last=1, latch the updated values into out_* and go to HOLD.
    - No accept: hold all values.
  - HOLD: out_valid=1, in_ready=0, and out_min/out_max/out_count are stable.
    - On out_ready=1, go to IDLE at the next edge with out_valid=0.
    - Without out_ready, stay in HOLD indefinitely.
- Latency: out_valid rises in the cycle after the edge that accepts the in_last beat. Result values become valid in that same cycle.
- in_ready is a combinational decode of state only. It does not depend on out_ready, so there is no same-cycle pass-through.
  - If in_valid is asserted during HOLD, the beat is not taken and must be held by the upstream.
  - Earliest next accept is the cycle after the result is consumed (one bubble per frame).
- Compare rules:
  - Compares are unsigned and full DATA_W.
  - Ties leave the stored value unchanged (values are equal anyway).
- The min/max/count latch into out_* occurs only on the last beat. out_* retain the previous frame's values while a new frame accumulates.
- A single-beat frame (IDLE accept with in_last=1) gives out_min=out_max=in_data, out_count=1.
- Counter saturation: once run_cnt=2^CNT_W-1, further beats leave it there. Min/max continue to update.
- in_data, in_last and out_ready are ignored when not qualified by their valid/state condition.

Test Plan:
- Reset then frame 0x30,0x05,0xF0,0x42 (last on 0x42), out_ready=1 → out_valid one cycle after the 0x42 accept, out_min=0x05, out_max=0xF0, out_count=4, then in_ready=1 next cycle.
- Single-beat frame 0x7A with in_last=1 → out_min=out_max=0x7A, out_count=1.
- Backpressure: frame 0x10,0x20 with out_ready=0 for 5 cycles while in_valid=1 with 0x99 → out_valid held, outputs stable, in_ready=0, 0x99 not accepted. After out_ready=1, 0x99 is accepted as the first beat of the next frame.
- Input gaps: frame 0xFF, idle 3 cycles, 0x00 last → out_min=0x00, out_max=0xFF, out_count=2.
- Saturation with CNT_W=4: 20 beats of values 1..20 → out_count=15, out_min=1, out_max=20.
- Async reset asserted mid-ACCUM after 0x01,0x02 (between edges) → outputs zero immediately, out_valid=0. The following frame 0x55 last gives min=max=0x55, count=1.

Source files
------------

// File: rtl/min_max_stream_reducer.sv
// Streaming frame reducer: running unsigned min/max and a saturating sample
// count, presented as a registered result on a valid/ready handshake.
module min_max_stream_reducer #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_min,
    output logic [DATA_W-1:0] out_max,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_valid,
    input  logic              out_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] run_min_q, run_min_d;
    logic [DATA_W-1:0] run_max_q, run_max_d;
    logic [CNT_W-1:0]  run_cnt_q, run_cnt_d;
    logic [DATA_W-1:0] out_min_q, out_min_d;
    logic [DATA_W-1:0] out_max_q, out_max_d;
    logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
    logic              out_valid_q, out_valid_d;

    logic              accept;
    logic [DATA_W-1:0] upd_min;
    logic [DATA_W-1:0] upd_max;
    logic [CNT_W-1:0]  upd_cnt;

    // Ready depends on state only, so a held result always costs one bubble.
    assign in_ready  = (state_q != HOLD);
    assign accept    = in_valid & in_ready;
    assign out_min   = out_min_q;
    assign out_max   = out_max_q;
    assign out_count = out_cnt_q;
    assign out_valid = out_valid_q;

    assign upd_min = (in_data < run_min_q) ? in_data : run_min_q;
    assign upd_max = (in_data > run_max_q) ? in_data : run_max_q;
    assign upd_cnt = (run_cnt_q == CNT_MAX) ? run_cnt_q : run_cnt_q + CNT_ONE;

    always_comb begin
        state_d     = state_q;
        run_min_d   = run_min_q;
        run_max_d   = run_max_q;
        run_cnt_d   = run_cnt_q;
        out_min_d   = out_min_q;
        out_max_d   = out_max_q;
        out_cnt_d   = out_cnt_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    run_min_d = in_data;
                    run_max_d = in_data;
                    run_cnt_d = CNT_ONE;
                    if (in_last) begin
                        out_min_d   = in_data;
                        out_max_d   = in_data;
                        out_cnt_d   = CNT_ONE;
                        out_valid_d = 1'b1;
                        state_d     = HOLD;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (accept) begin
                    run_min_d = upd_min;
                    run_max_d = upd_max;
                    run_cnt_d = upd_cnt;
                    if (in_last) begin
                        out_min_d   = upd_min;
                        out_max_d   = upd_max;
                        out_cnt_d   = upd_cnt;
                        out_valid_d = 1'b1;
                        state_d     = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            run_min_q   <= '0;
            run_max_q   <= '0;
            run_cnt_q   <= '0;
            out_min_q   <= '0;
            out_max_q   <= '0;
            out_cnt_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_min_q   <= run_min_d;
            run_max_q   <= run_max_d;
            run_cnt_q   <= run_cnt_d;
            out_min_q   <= out_min_d;
            out_max_q   <= out_max_d;
            out_cnt_q   <= out_cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_min_max_stream_reducer.sv
// Scoreboard bench for min_max_stream_reducer: frames go through a queue
// model, a monitor pops and compares each presented result.
module tb_min_max_stream_reducer;

    localparam int DW = 8;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic [DW-1:0] out_min;
    logic [DW-1:0] out_max;
    logic [CW-1:0] out_count;
    logic          out_valid;
    logic          out_ready;

    min_max_stream_reducer #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready),
        .out_min(out_min), .out_max(out_max), .out_count(out_count),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] mn;
        logic [DW-1:0] mx;
        logic [CW-1:0] cnt;
        int            cyc;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] frame[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            rdy_mode = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Frame statistics computed directly from the list of accepted samples.
    function automatic exp_t reduce_frame();
        exp_t e;
        int   n;
        n = frame.size();
        e.mn = frame[0];
        e.mx = frame[0];
        foreach (frame[i]) begin
            if (frame[i] < e.mn) e.mn = frame[i];
            if (frame[i] > e.mx) e.mx = frame[i];
        end
        e.cnt = CW'((n > CMAX) ? CMAX : n);
        e.cyc = 0;
        return e;
    endfunction

    task automatic send(input logic [DW-1:0] d, input logic last);
        int   n;
        exp_t e;
        in_data  = d;
        in_valid = 1'b1;
        in_last  = last;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 500) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) fail_now("accept_timeout");
        @(posedge clk);
        #1;
        frame.push_back(d);
        if (last) begin
            e = reduce_frame();
            e.cyc = cyc;
            sb.push_back(e);
            frame.delete();
        end
        in_valid = 1'b0;
        in_last  = 1'($urandom_range(0, 1));
        in_data  = DW'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 3000) begin
            n++;
            @(negedge clk);
        end
        if (sb.size() != 0 || out_valid) fail_now("drain_timeout");
        @(posedge clk);
        #1;
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'b0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: one pop per presented result, stability checks while held.
    initial begin
        exp_t cur;
        bit   held;
        held = 1'b0;
        cur = '{default: 0};
        forever begin
            @(negedge clk);
            if (rst) begin
                held = 1'b0;
            end else if (out_valid) begin
                if (!held) begin
                    if (sb.size() == 0) begin
                        fail_now("unexpected_result");
                    end else begin
                        cur = sb.pop_front();
                        chk("latency", cyc, cur.cyc);
                        chk("out_min", out_min, cur.mn);
                        chk("out_max", out_max, cur.mx);
                        chk("out_count", out_count, cur.cnt);
                    end
                end else begin
                    chk("hold_min", out_min, cur.mn);
                    chk("hold_max", out_max, cur.mx);
                    chk("hold_count", out_count, cur.cnt);
                end
                chk("in_ready_in_hold", in_ready, 0);
                held = !out_ready;
            end else begin
                held = 1'b0;
            end
        end
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        #12;
        chk("rst_out_min", out_min, 0);
        chk("rst_out_max", out_max, 0);
        chk("rst_out_count", out_count, 0);
        chk("rst_out_valid", out_valid, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_in_ready", in_ready, 1);

        send(8'h30, 0);
        send(8'h05, 0);
        send(8'hF0, 0);
        send(8'h42, 1);
        wait_drain();
        chk("in_ready_after_frame", in_ready, 1);

        send(8'h7A, 1);
        wait_drain();

        rdy_mode = 1;
        send(8'h10, 0);
        send(8'h20, 1);
        fork
            begin
                repeat (6) @(posedge clk);
                #2 rdy_mode = 0;
            end
        join_none
        send(8'h99, 1);
        wait_drain();

        send(8'hFF, 0);
        idle(3);
        send(8'h00, 1);
        wait_drain();

        for (int i = 1; i <= 20; i++) send(DW'(i), (i == 20));
        wait_drain();

        rdy_mode = 2;
        for (int f = 0; f < 40; f++) begin
            int len;
            len = $urandom_range(1, 22);
            for (int b = 0; b < len; b++) begin
                logic [DW-1:0] d;
                if (f % 3 == 0) d = DW'($urandom_range(60, 63));
                else d = DW'($urandom);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                send(d, (b == len - 1));
            end
        end
        wait_drain();

        rdy_mode = 0;
        send(8'h01, 0);
        send(8'h02, 0);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_min", out_min, 0);
        chk("arst_out_max", out_max, 0);
        chk("arst_out_count", out_count, 0);
        chk("arst_out_valid", out_valid, 0);
        frame.delete();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        send(8'h55, 1);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
